cnt_readout: RTL and testbench

- Downstream consumer of a bank of N-bit event counters in the USB interface.
- On a snapshot request it latches all counter values coherently into a shadow register and streams them as 16-bit words over a valid/ready link toward the USB transmit path.
- It can optionally drive the counters' clear inputs so that reading also resets them (clear-on-read).

---
 rtl/cnt_readout_pkg.sv | 32 +++
 rtl/sat_cnt8.sv | 24 ++
 rtl/cnt_readout.sv | 145 ++++++++++++++
 tb/tb_cnt_readout.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_readout_pkg.sv
// Shared definitions for the counter readout block: word width, FSM state
// encodings, header field layout and the drop counter ceiling.
package cnt_readout_pkg;

    localparam int WORD_W = 16;

    // FSM state encodings kept as plain constants so older tools that lack
    // enum support can still read the state register.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HDR  = 2'd1;
    localparam state_t ST_DATA = 2'd2;

    // Header word layout: drop count in the upper byte, counter count below.
    localparam int HDR_DROP_MSB = 15;
    localparam int HDR_DROP_LSB = 8;
    localparam int HDR_CNT_MSB  = 7;
    localparam int HDR_CNT_LSB  = 0;

    localparam logic [7:0] DROP_MAX = 8'd255;

    // Assemble the frame header from the drop count and the number of counters.
    function automatic logic [WORD_W-1:0] make_header(input logic [7:0] drop,
                                                      input logic [7:0] ncnt);
        logic [WORD_W-1:0] h;
        h = '0;
        h[HDR_DROP_MSB:HDR_DROP_LSB] = drop;
        h[HDR_CNT_MSB:HDR_CNT_LSB]   = ncnt;
        return h;
    endfunction

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit saturating counter. Clear wins over increment, but an increment in
// the same cycle as a clear is not lost: the count restarts at 1.
import cnt_readout_pkg::*;

module sat_cnt8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] q
);

    // Count events, holding at the ceiling; a clear restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 8'd0;
        end else if (clr) begin
            q <= inc ? 8'd1 : 8'd0;
        end else if (inc && (q != DROP_MAX)) begin
            q <= q + 8'd1;
        end
    end

endmodule

// File: rtl/cnt_readout.sv
// Counter bank readout: on a snapshot request the whole bank is captured into
// a shadow register in one edge, then streamed as a header word followed by
// 16-bit data words over a valid/ready link. Snapshot requests that arrive
// while a frame is in flight are counted as drops and reported in the next
// header.
import cnt_readout_pkg::*;

module cnt_readout #(
    parameter int NCNT = 4,
    parameter int N    = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NCNT*N-1:0]   cnt_i,
    input  logic                snap_i,
    input  logic                clr_on_rd_i,
    output logic [NCNT-1:0]     clr_o,
    output logic                busy_o,
    output logic [WORD_W-1:0]   data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                last_o
);

    // Flattened counter layout means data word k is simply bits
    // [k*16+15 : k*16] of the shadow: counter 0 first, low half first.
    localparam int WPC    = N / WORD_W;
    localparam int NWORDS = NCNT * WPC;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [7:0] NCNT_B = 8'(NCNT);

    state_t                state;
    logic [NCNT*N-1:0]     shadow;
    logic [IDX_W-1:0]      idx;
    logic [7:0]            drop_cnt;

    logic                  accept;
    logic                  drop_inc;
    logic                  drop_clr;
    logic [IDX_W-1:0]      next_idx;
    logic [WORD_W-1:0]     next_word;
    logic                  next_last;

    assign accept   = valid_o & ready_i;
    assign drop_inc = snap_i & (state != ST_IDLE);
    assign drop_clr = (state == ST_HDR) & accept;

    // Counts snapshot requests that could not be honoured; cleared once the
    // header carrying the count has been delivered.
    sat_cnt8 u_drop_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .inc   (drop_inc),
        .clr   (drop_clr),
        .q     (drop_cnt)
    );

    // Clear strobes follow the accepted snapshot combinationally so the
    // counters clear on the very edge the shadow captures them.
    always_comb begin
        clr_o = '0;
        if (rst_n_i && (state == ST_IDLE) && snap_i && clr_on_rd_i) begin
            clr_o = {NCNT{1'b1}};
        end
    end

    // Index of the word to present after the current one is accepted:
    // the first data word when leaving the header, otherwise the next one.
    always_comb begin
        next_idx = '0;
        if (state == ST_DATA) begin
            next_idx = idx + 1'b1;
        end
    end

    // Word-select mux over the shadow register.
    always_comb begin
        next_word = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (next_idx == IDX_W'(k)) begin
                next_word = shadow[k*WORD_W +: WORD_W];
            end
        end
    end

    assign next_last = (next_idx == LAST_IDX);

    // Frame sequencer: capture, header, data words, back to idle. Outputs
    // only change on an accept, which keeps data_o/last_o stable under
    // backpressure.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            shadow  <= '0;
            idx     <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            busy_o  <= 1'b0;
            data_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (snap_i) begin
                        shadow  <= cnt_i;
                        state   <= ST_HDR;
                        valid_o <= 1'b1;
                        busy_o  <= 1'b1;
                        last_o  <= 1'b0;
                        data_o  <= make_header(drop_cnt, NCNT_B);
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        state  <= ST_DATA;
                        idx    <= next_idx;
                        data_o <= next_word;
                        last_o <= next_last;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        if (last_o) begin
                            state   <= ST_IDLE;
                            valid_o <= 1'b0;
                            last_o  <= 1'b0;
                            busy_o  <= 1'b0;
                        end else begin
                            idx    <= next_idx;
                            data_o <= next_word;
                            last_o <= next_last;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    valid_o <= 1'b0;
                    last_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_readout.sv
// Bench for cnt_readout (NCNT=4, N=32): a table of frames is driven through
// the block while a monitor pops expected words from a scoreboard queue on
// every accepted transfer. Hand-written sequences cover drops, snapshot
// collisions with header/last accept, and reset in the middle of a frame.
module tb_cnt_readout;

    localparam int NCNT = 4;
    localparam int N    = 32;

    logic               clk;
    logic               rst_n_i;
    logic [NCNT*N-1:0]  cnt_i;
    logic               snap_i;
    logic               clr_on_rd_i;
    logic [NCNT-1:0]    clr_o;
    logic               busy_o;
    logic [15:0]        data_o;
    logic               valid_o;
    logic               ready_i;
    logic               last_o;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } sb_t;

    typedef struct {
        logic [127:0]      cnt;
        logic              clr;
        int                stall_word;
        int                stall_cycles;
        logic [8:0][15:0]  exp;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[4];

    int compared;
    int mismatched;
    int accepted_count;
    bit frame_done;
    bit expect_idle;

    cnt_readout #(.NCNT(NCNT), .N(N)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .cnt_i       (cnt_i),
        .snap_i      (snap_i),
        .clr_on_rd_i (clr_on_rd_i),
        .clr_o       (clr_o),
        .busy_o      (busy_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and report a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: on the falling edge, a valid&ready pair means the word is
    // transferred on the next rising edge, so compare it against the queue.
    always @(negedge clk) begin
        if (rst_n_i) begin
            if (expect_idle) begin
                checkOutput("idle_valid", 32'(valid_o), 32'd0);
                checkOutput("idle_busy", 32'(busy_o), 32'd0);
                checkOutput("idle_last", 32'(last_o), 32'd0);
                expect_idle = 1'b0;
            end
            if (busy_o) begin
                checkOutput("clr_in_frame", 32'(clr_o), 32'd0);
            end
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_word", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    checkOutput("word_data", 32'(data_o), 32'(e.data));
                    checkOutput("word_last", 32'(last_o), 32'(e.last));
                end
                accepted_count++;
                if (last_o) begin
                    expect_idle = 1'b1;
                    frame_done  = 1'b1;
                end
            end
        end
    end

    // Drive one frame of vector v and wait for it to drain. Optional extras:
    // dropped snapshot pulses during a stall, a snapshot in the header-accept
    // cycle, or a snapshot in the last-word-accept cycle.
    task automatic applyStimulus(input int v, input logic [15:0] hdr, input int drop_snaps,
                                 input bit snap_at_hdr, input bit snap_at_last);
        int sw;
        int sc;
        int guard;
        bit stalled;
        sw = vecs[v].stall_word;
        sc = vecs[v].stall_cycles;
        if (drop_snaps > 0) begin
            sw = 2;
            sc = 2 * drop_snaps + 1;
        end
        accepted_count = 0;
        frame_done     = 1'b0;
        stalled        = 1'b0;
        cnt_i          = vecs[v].cnt;
        clr_on_rd_i    = vecs[v].clr;
        ready_i        = 1'b1;
        sb.push_back({hdr, 1'b0});
        for (int k = 1; k <= 8; k++) begin
            sb.push_back({vecs[v].exp[k], (k == 8)});
        end
        snap_i = 1'b1;
        #1;
        checkOutput("clr_at_snap", 32'(clr_o), vecs[v].clr ? 32'hF : 32'h0);
        checkOutput("busy_before", 32'(busy_o), 32'd0);
        tick();
        snap_i = 1'b0;
        cnt_i  = ~vecs[v].cnt;
        checkOutput("hdr_valid", 32'(valid_o), 32'd1);
        checkOutput("hdr_data", 32'(data_o), 32'(hdr));
        checkOutput("hdr_busy", 32'(busy_o), 32'd1);
        if (snap_at_hdr) begin
            snap_i = 1'b1;
            tick();
            snap_i = 1'b0;
        end
        guard = 0;
        while (!frame_done && guard < 3000) begin
            if (!stalled && sw >= 0 && accepted_count == sw) begin
                stalled = 1'b1;
                ready_i = 1'b0;
                for (int c = 0; c < sc; c++) begin
                    if (drop_snaps > 0) snap_i = ((c % 2) == 0) && ((c / 2) < drop_snaps);
                    tick();
                    checkOutput("stall_data", 32'(data_o), (sw == 0) ? 32'(hdr) : 32'(vecs[v].exp[sw]));
                    checkOutput("stall_valid", 32'(valid_o), 32'd1);
                end
                snap_i  = 1'b0;
                ready_i = 1'b1;
            end
            if (snap_at_last && accepted_count == 8) snap_i = 1'b1;
            tick();
            snap_i = 1'b0;
            guard++;
        end
        if (!frame_done) begin
            checkOutput("frame_timeout", 32'd0, 32'd1);
        end
        tick();
        tick();
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("word_count", 32'(accepted_count), 32'd9);
        sb.delete();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        compared       = 0;
        mismatched     = 0;
        accepted_count = 0;
        frame_done     = 1'b0;
        expect_idle    = 1'b0;

        vecs[0].cnt = {32'h77778888, 32'h55556666, 32'h33334444, 32'h11112222};
        vecs[0].clr = 1'b0; vecs[0].stall_word = -1; vecs[0].stall_cycles = 0;
        vecs[0].exp = {16'h7777, 16'h8888, 16'h5555, 16'h6666, 16'h3333, 16'h4444, 16'h1111, 16'h2222, 16'h0004};
        vecs[1].cnt = vecs[0].cnt;
        vecs[1].clr = 1'b0; vecs[1].stall_word = 3; vecs[1].stall_cycles = 3;
        vecs[1].exp = vecs[0].exp;
        vecs[2].cnt = {32'hDEADBEEF, 32'h00000010, 32'h0000FFFF, 32'hAAAA5555};
        vecs[2].clr = 1'b1; vecs[2].stall_word = -1; vecs[2].stall_cycles = 0;
        vecs[2].exp = {16'hDEAD, 16'hBEEF, 16'h0000, 16'h0010, 16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555, 16'h0004};
        vecs[3].cnt = {32'h00018000, 32'hFFFF0000, 32'h89ABCDEF, 32'h01234567};
        vecs[3].clr = 1'b0; vecs[3].stall_word = 0; vecs[3].stall_cycles = 2;
        vecs[3].exp = {16'h0001, 16'h8000, 16'hFFFF, 16'h0000, 16'h89AB, 16'hCDEF, 16'h0123, 16'h4567, 16'h0004};

        // Reset with arbitrary inputs, including a clear-on-read snapshot.
        rst_n_i     = 1'b0;
        snap_i      = 1'b1;
        clr_on_rd_i = 1'b1;
        ready_i     = 1'b1;
        cnt_i       = {$urandom, $urandom, $urandom, $urandom};
        #3;
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_last", 32'(last_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_data", 32'(data_o), 32'd0);
        checkOutput("rst_clr", 32'(clr_o), 32'd0);
        tick();
        tick();
        snap_i  = 1'b0;
        rst_n_i = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("post_rst_valid", 32'(valid_o), 32'd0);
        checkOutput("post_rst_busy", 32'(busy_o), 32'd0);
        checkOutput("post_rst_last", 32'(last_o), 32'd0);
        checkOutput("post_rst_data", 32'(data_o), 32'd0);
        checkOutput("post_rst_clr", 32'(clr_o), 32'd0);

        // Table-driven frames: basic, backpressure, clear-on-read, header stall.
        for (int i = 0; i < 4; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(i, 16'h0004, 0, 1'b0, 1'b0);
        end

        // Three dropped snapshots during a frame show up in the next header only.
        $display("[TB] drop sequence");
        applyStimulus(0, 16'h0004, 3, 1'b0, 1'b0);
        applyStimulus(0, 16'h0304, 0, 1'b0, 1'b0);
        applyStimulus(0, 16'h0004, 0, 1'b0, 1'b0);

        // Snapshot coinciding with the header accept leaves a count of one.
        $display("[TB] snap at header accept");
        applyStimulus(0, 16'h0004, 0, 1'b1, 1'b0);
        applyStimulus(0, 16'h0104, 0, 1'b0, 1'b0);

        // Snapshot coinciding with the last-word accept is a drop, not a new frame.
        $display("[TB] snap at last accept");
        applyStimulus(0, 16'h0004, 0, 1'b0, 1'b1);
        applyStimulus(0, 16'h0104, 0, 1'b0, 1'b0);

        // Drop count saturates.
        $display("[TB] drop saturation");
        applyStimulus(0, 16'h0004, 300, 1'b0, 1'b0);
        applyStimulus(0, 16'hFF04, 0, 1'b0, 1'b0);

        // Reset while word 5 is pending, then a fresh full frame.
        $display("[TB] reset mid-frame");
        accepted_count = 0;
        frame_done     = 1'b0;
        cnt_i          = vecs[0].cnt;
        clr_on_rd_i    = 1'b1;
        ready_i        = 1'b1;
        sb.push_back({16'h0004, 1'b0});
        for (int k = 1; k <= 8; k++) begin
            sb.push_back({vecs[0].exp[k], (k == 8)});
        end
        snap_i = 1'b1;
        tick();
        snap_i = 1'b0;
        guard  = 0;
        while (accepted_count < 5 && guard < 100) begin
            tick();
            guard++;
        end
        checkOutput("reach_word5", 32'(accepted_count), 32'd5);
        ready_i = 1'b0;
        tick();
        checkOutput("word5_pending", 32'(data_o), 32'h6666);
        snap_i  = 1'b1;
        rst_n_i = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(valid_o), 32'd0);
        checkOutput("midrst_busy", 32'(busy_o), 32'd0);
        checkOutput("midrst_last", 32'(last_o), 32'd0);
        checkOutput("midrst_clr", 32'(clr_o), 32'd0);
        sb.delete();
        tick();
        snap_i  = 1'b0;
        rst_n_i = 1'b1;
        tick();
        checkOutput("after_rst_valid", 32'(valid_o), 32'd0);
        applyStimulus(0, 16'h0004, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
